// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two read ports with busy flags, two write ports,
// the issue (destination-pending) port and the ready flag.
interface regfile_sb_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1_raddr;
  logic [AW-1:0]   rs2_raddr;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            wa_en;
  logic [AW-1:0]   wa_addr;
  logic [XLEN-1:0] wa_data;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            ready;

  modport master (
    output rs1_raddr, rs2_raddr,
    output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    output issue_en, issue_rd,
    input  rs1_rdata, rs2_rdata, rs1_busy, rs2_busy, ready
  );

  modport slave (
    input  rs1_raddr, rs2_raddr,
    input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    input  issue_en, issue_rd,
    output rs1_rdata, rs2_rdata, rs1_busy, rs2_busy, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with scoreboard busy bits and a post-reset clearing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy-clear to the read ports.
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {INIT, RUN} state_e;

  state_e          state;
  logic [AW-1:0]   sweep_cnt;
  logic            ready_q;
  logic            run;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  logic [AW-1:0]   raddr [2];
  logic [XLEN-1:0] rdata [2];
  logic            rbusy [2];

  assign run = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT;
      sweep_cnt <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == AW'(NREG - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          state   <= RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the array has no reset term; the INIT sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        regs[sweep_cnt] <= '0;
      end else begin
        if (bus.wa_en && bus.wa_addr != '0) regs[bus.wa_addr] <= bus.wa_data;
        // Port B is assigned last so it wins a same-address collision.
        if (bus.wb_en && bus.wb_addr != '0) regs[bus.wb_addr] <= bus.wb_data;
      end
    end
  end

  // Writes clear pending bits before issue sets them, so a same-cycle issue keeps the bit set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else if (run) begin
      if (bus.wa_en) busy[bus.wa_addr] <= 1'b0;
      if (bus.wb_en) busy[bus.wb_addr] <= 1'b0;
      if (bus.issue_en && bus.issue_rd != '0) busy[bus.issue_rd] <= 1'b1;
    end
  end

  assign raddr[0] = bus.rs1_raddr;
  assign raddr[1] = bus.rs2_raddr;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[raddr[p]];
      rbusy[p] = busy[raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (bus.wb_en && bus.wb_addr == raddr[p]) begin
        rdata[p] = bus.wb_data;
        rbusy[p] = 1'b0;
      end else if (bus.wa_en && bus.wa_addr == raddr[p]) begin
        rdata[p] = bus.wa_data;
        rbusy[p] = 1'b0;
      end
`endif
      if (!run || raddr[p] == '0) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign bus.rs1_rdata = rdata[0];
  assign bus.rs2_rdata = rdata[1];
  assign bus.rs1_busy  = rbusy[0];
  assign bus.rs2_busy  = rbusy[1];
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations are queued as stimulus is driven
// and compared against the DUT outputs later in the same cycle.
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef enum {RD1, RD2, BUSY1, BUSY2, RDY} obs_e;
  typedef struct {
    string       tag;
    obs_e        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Inputs settle, then every queued expectation is compared well before the next rising edge.
  task automatic drain();
    exp_t        e;
    logic [63:0] act;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        RD1:     act = bus.rs1_rdata;
        RD2:     act = bus.rs2_rdata;
        BUSY1:   act = 64'(bus.rs1_busy);
        BUSY2:   act = 64'(bus.rs2_busy);
        default: act = 64'(bus.ready);
      endcase
      check(e.tag, act, e.exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.wa_en    = 1'b0;
    bus.wb_en    = 1'b0;
    bus.issue_en = 1'b0;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wa_en = 1'b1; bus.wa_addr = a; bus.wa_data = d;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.issue_en = 1'b1; bus.issue_rd = a;
  endtask

  task automatic pulse_reset();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // Observes ncyc+1 cycles after reset release while hammering the write/issue ports.
  task automatic sweep(input string name, input int ncyc, input logic [AW-1:0] rd);
    for (int i = 0; i <= ncyc; i++) begin
      if (i > 0) next_cycle();
      bus.rs1_raddr = rd;
      if (i < NREG) begin
        wr_a(rd, 64'hDEAD_BEEF);
        wr_b(5'd6, 64'hCAFE);
        issue(rd);
      end
      expect_out($sformatf("%s_ready_%0d", name, i), RDY, (i >= NREG) ? 64'd1 : 64'd0);
      expect_out($sformatf("%s_rd1_%0d", name, i), RD1, 64'd0);
      expect_out($sformatf("%s_busy1_%0d", name, i), BUSY1, 64'd0);
      drain();
    end
  endtask

  initial begin
    bus.rs1_raddr = '0; bus.rs2_raddr = '0;
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.issue_en = 1'b0; bus.issue_rd = '0;

    pulse_reset();
    sweep("init", NREG, 5'd5);

    next_cycle();
    bus.rs1_raddr = 5'd5; bus.rs2_raddr = 5'd6;
    expect_out("init_wr_ignored_x5", RD1, 64'd0);
    expect_out("init_wr_ignored_x6", RD2, 64'd0);
    expect_out("init_issue_ignored", BUSY1, 64'd0);
    drain();

    next_cycle();
    wr_a(5'd3, 64'h1234); bus.rs1_raddr = 5'd3;
    expect_out("x3_same_cycle", RD1, BYP ? 64'h1234 : 64'd0);
    drain();

    next_cycle();
    wr_a(5'd0, 64'hFFFF); bus.rs1_raddr = 5'd3; bus.rs2_raddr = 5'd0;
    expect_out("x3_read", RD1, 64'h1234);
    expect_out("x0_same_cycle", RD2, 64'd0);
    drain();

    next_cycle();
    bus.rs1_raddr = 5'd0;
    expect_out("x0_read", RD1, 64'd0);
    expect_out("x0_busy", BUSY1, 64'd0);
    drain();

    next_cycle();
    wr_a(5'd7, 64'hAA); wr_b(5'd7, 64'hBB); bus.rs1_raddr = 5'd7;
    expect_out("x7_collide_same", RD1, BYP ? 64'hBB : 64'd0);
    drain();

    next_cycle();
    bus.rs1_raddr = 5'd7;
    expect_out("x7_port_b_wins", RD1, 64'hBB);
    drain();

    next_cycle();
    issue(5'd9); bus.rs1_raddr = 5'd9;
    expect_out("x9_busy_pre", BUSY1, 64'd0);
    drain();

    next_cycle();
    bus.rs1_raddr = 5'd9; bus.rs2_raddr = 5'd9;
    expect_out("x9_busy_set1", BUSY1, 64'd1);
    expect_out("x9_busy_set2", BUSY2, 64'd1);
    drain();

    next_cycle();
    wr_a(5'd9, 64'h55); bus.rs1_raddr = 5'd9;
    expect_out("x9_busy_wr_same", BUSY1, BYP ? 64'd0 : 64'd1);
    expect_out("x9_data_wr_same", RD1, BYP ? 64'h55 : 64'd0);
    drain();

    next_cycle();
    bus.rs1_raddr = 5'd9;
    expect_out("x9_busy_cleared", BUSY1, 64'd0);
    expect_out("x9_data", RD1, 64'h55);
    drain();

    next_cycle();
    issue(5'd9); wr_a(5'd9, 64'h66); bus.rs1_raddr = 5'd9;
    expect_out("x9_iss_wr_same", BUSY1, 64'd0);
    expect_out("x9_iss_wr_data", RD1, BYP ? 64'h66 : 64'h55);
    drain();

    next_cycle();
    bus.rs1_raddr = 5'd9;
    expect_out("x9_new_producer", BUSY1, 64'd1);
    expect_out("x9_data2", RD1, 64'h66);
    drain();

    next_cycle();
    issue(5'd0);
    next_cycle();
    bus.rs1_raddr = 5'd0;
    expect_out("x0_never_busy", BUSY1, 64'd0);
    drain();

    next_cycle();
    issue(5'd12);
    next_cycle();
    wr_b(5'd12, 64'h99); bus.rs2_raddr = 5'd12;
    expect_out("x12_busy_wb_same", BUSY2, BYP ? 64'd0 : 64'd1);
    drain();

    next_cycle();
    bus.rs2_raddr = 5'd12;
    expect_out("x12_busy_wb_clr", BUSY2, 64'd0);
    expect_out("x12_data", RD2, 64'h99);
    drain();

    next_cycle();
    issue(5'd4);
    next_cycle();
    wr_a(5'd4, 64'h77); bus.rs2_raddr = 5'd4; bus.rs1_raddr = 5'd3;
    expect_out("x4_bypass_data", RD2, BYP ? 64'h77 : 64'd0);
    expect_out("x4_bypass_busy", BUSY2, BYP ? 64'd0 : 64'd1);
    expect_out("rs1_independent", RD1, 64'h1234);
    drain();

    next_cycle();
    bus.rs2_raddr = 5'd4;
    expect_out("x4_data", RD2, 64'h77);
    expect_out("x4_busy", BUSY2, 64'd0);
    drain();

    next_cycle();
    issue(5'd3);
    next_cycle();
    bus.rs1_raddr = 5'd3;
    expect_out("x3_busy_before_rst", BUSY1, 64'd1);
    expect_out("x3_before_rst", RD1, 64'h1234);
    drain();

    pulse_reset();
    sweep("partial", 10, 5'd3);
    pulse_reset();
    sweep("rerun", NREG, 5'd3);

    next_cycle();
    bus.rs1_raddr = 5'd3; bus.rs2_raddr = 5'd7;
    expect_out("x3_cleared", RD1, 64'd0);
    expect_out("x7_cleared", RD2, 64'd0);
    expect_out("x3_busy_cleared", BUSY1, 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
